// File: rtl/asm_frame_packer.sv
// Frames RS codewords: optional attached sync marker, payload length enforcement,
// pad to the output word width, and MSB-lane-first packing into AXI-Stream words.
module asm_frame_packer #(
    parameter int          ASM_BYTES   = 4,
    parameter logic [63:0] ASM_VALUE   = 64'h0000_0000_1ACF_FC1D,
    parameter int          PAYLOAD_LEN = 255,
    parameter int          OUT_BYTES   = 4,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input  logic                   core_clk,
    input  logic                   rst,
    input  logic                   cfg_asm_en,
    input  logic [7:0]             s_axis_input_tdata,
    input  logic                   s_axis_input_tvalid,
    input  logic                   s_axis_input_tlast,
    output logic                   s_axis_input_tready,
    output logic [8*OUT_BYTES-1:0] m_axis_output_tdata,
    output logic                   m_axis_output_tvalid,
    output logic                   m_axis_output_tlast,
    input  logic                   m_axis_output_tready,
    output logic [15:0]            frame_cnt,
    output logic                   err_short,
    output logic                   err_long
);

    localparam int DCNT_W  = $clog2(PAYLOAD_LEN) + 1;
    localparam int LANE_W  = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam int WORD_W  = 8 * OUT_BYTES;
    localparam int P_ON_I  = (OUT_BYTES - ((ASM_BYTES + PAYLOAD_LEN) % OUT_BYTES)) % OUT_BYTES;
    localparam int P_OFF_I = (OUT_BYTES - (PAYLOAD_LEN % OUT_BYTES)) % OUT_BYTES;

    localparam logic [4:0]        P_ON      = 5'(P_ON_I);
    localparam logic [4:0]        P_OFF     = 5'(P_OFF_I);
    localparam logic [DCNT_W-1:0] DATA_LAST = DCNT_W'(PAYLOAD_LEN - 1);
    localparam logic [3:0]        ASM_LAST  = 4'(ASM_BYTES - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(OUT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASM,
        S_DATA,
        S_FILL,
        S_PAD
    } state_t;

    state_t              state;
    logic                asm_en_q;
    logic [3:0]          asm_cnt;
    logic [DCNT_W-1:0]   data_cnt;
    logic [4:0]          pad_cnt;
    logic [LANE_W-1:0]   lane;
    logic [WORD_W-1:0]   asm_word_p0;

    logic                slot_ok;
    logic [4:0]          p_cur;
    logic                payload_last;
    logic                pad_last;
    state_t              post_state;
    logic                byte_vld_p0;
    logic [7:0]          byte_dat_p0;
    logic                byte_end_p0;
    logic [WORD_W-1:0]   word_next;

    // Marker bytes go out most significant byte first.
    function automatic logic [7:0] marker_byte(input logic [3:0] idx);
        logic [63:0] sh;
        sh = ASM_VALUE >> (8 * (ASM_BYTES - 1 - int'(idx)));
        return sh[7:0];
    endfunction

    // Byte slot: at most one byte per cycle; blocked only when it would complete
    // a word while the previous word is still stalled in the output register.
    always_comb begin
        slot_ok      = !(lane == LANE_LAST && m_axis_output_tvalid && !m_axis_output_tready);
        p_cur        = asm_en_q ? P_ON : P_OFF;
        payload_last = (data_cnt == DATA_LAST);
        pad_last     = (pad_cnt == p_cur - 5'd1);
        post_state   = (p_cur != 5'd0) ? S_PAD : S_IDLE;

        s_axis_input_tready = (state == S_DATA) && slot_ok;

        byte_vld_p0 = 1'b0;
        byte_dat_p0 = PAD_BYTE;
        byte_end_p0 = 1'b0;
        case (state)
            S_ASM: begin
                byte_vld_p0 = slot_ok;
                byte_dat_p0 = marker_byte(asm_cnt);
            end
            S_DATA: begin
                byte_vld_p0 = s_axis_input_tvalid && s_axis_input_tready;
                byte_dat_p0 = s_axis_input_tdata;
                byte_end_p0 = payload_last && (p_cur == 5'd0);
            end
            S_FILL: begin
                byte_vld_p0 = slot_ok;
                byte_end_p0 = payload_last && (p_cur == 5'd0);
            end
            S_PAD: begin
                byte_vld_p0 = slot_ok;
                byte_end_p0 = pad_last;
            end
            default: begin
                byte_vld_p0 = 1'b0;
            end
        endcase

        word_next = (asm_word_p0 << 8) | WORD_W'(byte_dat_p0);
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            asm_en_q  <= 1'b0;
            asm_cnt   <= '0;
            data_cnt  <= '0;
            pad_cnt   <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (s_axis_input_tvalid) begin
                        asm_en_q <= cfg_asm_en;
                        state    <= cfg_asm_en ? S_ASM : S_DATA;
                    end
                end
                S_ASM: begin
                    if (byte_vld_p0) begin
                        if (asm_cnt == ASM_LAST) begin
                            asm_cnt <= '0;
                            state   <= S_DATA;
                        end else begin
                            asm_cnt <= asm_cnt + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (byte_vld_p0) begin
                        if (payload_last) begin
                            data_cnt <= '0;
                            err_long <= !s_axis_input_tlast;
                            state    <= post_state;
                        end else begin
                            data_cnt <= data_cnt + DCNT_W'(1);
                            if (s_axis_input_tlast) begin
                                err_short <= 1'b1;
                                state     <= S_FILL;
                            end
                        end
                    end
                end
                S_FILL: begin
                    if (byte_vld_p0) begin
                        if (payload_last) begin
                            data_cnt <= '0;
                            state    <= post_state;
                        end else begin
                            data_cnt <= data_cnt + DCNT_W'(1);
                        end
                    end
                end
                S_PAD: begin
                    if (byte_vld_p0) begin
                        if (pad_last) begin
                            pad_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            pad_cnt <= pad_cnt + 5'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage p0 -> output: assemble bytes by lane, hand the word over on the last lane.
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            lane                 <= '0;
            asm_word_p0          <= '0;
            m_axis_output_tdata  <= '0;
            m_axis_output_tvalid <= 1'b0;
            m_axis_output_tlast  <= 1'b0;
            frame_cnt            <= '0;
        end else begin
            if (m_axis_output_tvalid && m_axis_output_tready) begin
                m_axis_output_tvalid <= 1'b0;
                if (m_axis_output_tlast) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
            if (byte_vld_p0) begin
                asm_word_p0 <= word_next;
                if (lane == LANE_LAST) begin
                    lane                 <= '0;
                    m_axis_output_tdata  <= word_next;
                    m_axis_output_tvalid <= 1'b1;
                    m_axis_output_tlast  <= byte_end_p0;
                end else begin
                    lane <= lane + LANE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_asm_frame_packer.sv
// Bench for asm_frame_packer: a 4-byte-wide and an 8-byte-wide instance, checked
// against a frame-level byte model (marker + payload + fill + pad, chunked into words).
module tb_asm_frame_packer;

    logic core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    logic        rst;
    logic        cfg_asm_en;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        m_tready;
    int          sel;

    logic        s_tvalid_a, s_tvalid_b, s_tready_a, s_tready_b;
    logic [31:0] m_tdata_a;
    logic [63:0] m_tdata_b;
    logic        m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b;
    logic [15:0] fc_a, fc_b;
    logic        es_a, es_b, el_a, el_b;

    assign s_tvalid_a = s_tvalid && (sel == 0);
    assign s_tvalid_b = s_tvalid && (sel == 1);

    logic        s_tready_m, m_tvalid_m, m_tlast_m, es_m, el_m;
    logic [63:0] m_tdata_m;
    logic [15:0] fc_m;
    assign s_tready_m = sel ? s_tready_b : s_tready_a;
    assign m_tvalid_m = sel ? m_tvalid_b : m_tvalid_a;
    assign m_tlast_m  = sel ? m_tlast_b  : m_tlast_a;
    assign m_tdata_m  = sel ? m_tdata_b  : {32'h0, m_tdata_a};
    assign fc_m       = sel ? fc_b : fc_a;
    assign es_m       = sel ? es_b : es_a;
    assign el_m       = sel ? el_b : el_a;

    asm_frame_packer dut_a (
        .core_clk(core_clk), .rst(rst), .cfg_asm_en(cfg_asm_en),
        .s_axis_input_tdata(s_tdata), .s_axis_input_tvalid(s_tvalid_a),
        .s_axis_input_tlast(s_tlast), .s_axis_input_tready(s_tready_a),
        .m_axis_output_tdata(m_tdata_a), .m_axis_output_tvalid(m_tvalid_a),
        .m_axis_output_tlast(m_tlast_a), .m_axis_output_tready(m_tready),
        .frame_cnt(fc_a), .err_short(es_a), .err_long(el_a)
    );

    asm_frame_packer #(.OUT_BYTES(8)) dut_b (
        .core_clk(core_clk), .rst(rst), .cfg_asm_en(cfg_asm_en),
        .s_axis_input_tdata(s_tdata), .s_axis_input_tvalid(s_tvalid_b),
        .s_axis_input_tlast(s_tlast), .s_axis_input_tready(s_tready_b),
        .m_axis_output_tdata(m_tdata_b), .m_axis_output_tvalid(m_tvalid_b),
        .m_axis_output_tlast(m_tlast_b), .m_axis_output_tready(m_tready),
        .frame_cnt(fc_b), .err_short(es_b), .err_long(el_b)
    );

    int          total = 0;
    int          bad = 0;
    logic [7:0]  pay_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    bit          gotl_q[$];
    int          es_cnt, el_cnt, hold_viol;
    bit          timed_out;
    int          exp_fc[2];

    // Frame model: marker, PAYLOAD_LEN payload positions (zero after an early tlast),
    // zero pad up to a whole word, then MSB-first chunking.
    function automatic void build_exp(input int ob, input bit asm_en, input int tlast_idx);
        logic [7:0]  fb[$];
        logic [31:0] mk;
        logic [63:0] w;
        mk = 32'h1ACFFC1D;
        exp_q.delete();
        if (asm_en)
            for (int k = 3; k >= 0; k--) fb.push_back(mk[8*k +: 8]);
        for (int i = 0; i < 255; i++)
            fb.push_back((i < pay_q.size() && (tlast_idx < 0 || i <= tlast_idx)) ? pay_q[i] : 8'h00);
        while (fb.size() % ob != 0) fb.push_back(8'h00);
        for (int n = 0; n < fb.size() / ob; n++) begin
            w = '0;
            for (int k = 0; k < ob; k++) w = (w << 8) | 64'(fb[n*ob + k]);
            exp_q.push_back(w);
        end
    endfunction

    task automatic drive_frame(input int tlast_idx, input bit gaps, input bit stall,
                               input int abort_words, input int exp_n);
        int          idx = 0;
        int          tail = 0;
        int          ph = 0;
        bit          held = 0;
        bit          hs;
        logic [63:0] held_d;
        logic        held_l;
        got_q.delete(); gotl_q.delete();
        es_cnt = 0; el_cnt = 0; hold_viol = 0; timed_out = 1;
        s_tvalid = 0; s_tlast = 0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (idx < pay_q.size() && !s_tvalid) s_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (s_tvalid) begin
                s_tdata = pay_q[idx];
                s_tlast = (idx == tlast_idx);
            end
            m_tready = stall ? (ph % 3 == 0) : 1'b1;
            ph++;
            @(negedge core_clk);
            if (es_m) es_cnt++;
            if (el_m) el_cnt++;
            if (held && (!m_tvalid_m || m_tdata_m !== held_d || m_tlast_m !== held_l)) hold_viol++;
            held   = m_tvalid_m && !m_tready;
            held_d = m_tdata_m;
            held_l = m_tlast_m;
            if (m_tvalid_m && m_tready) begin
                got_q.push_back(m_tdata_m);
                gotl_q.push_back(m_tlast_m);
            end
            hs = s_tvalid && s_tready_m;
            @(posedge core_clk); #1;
            if (hs) begin
                idx++;
                s_tvalid = 0;
                s_tlast  = 0;
            end
            if (abort_words > 0 && got_q.size() >= abort_words) begin
                timed_out = 0;
                break;
            end
            if (got_q.size() >= exp_n) tail++;
            if (tail > 3) begin
                timed_out = 0;
                break;
            end
        end
        s_tvalid = 0; s_tlast = 0; m_tready = 1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge core_clk);
        @(negedge core_clk);
        total += 8;
        if (m_tvalid_a !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid_a); end
        if (m_tdata_a !== 32'h0) begin bad++; $display("FAIL reset_tdata got=%h want=0", m_tdata_a); end
        if (m_tlast_a !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", m_tlast_a); end
        if (s_tready_a !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b want=0", s_tready_a); end
        if (fc_a !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", fc_a); end
        if (es_a !== 1'b0 || el_a !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b want=00", es_a, el_a); end
        if (m_tvalid_b !== 1'b0) begin bad++; $display("FAIL reset_tvalid_w8 got=%b want=0", m_tvalid_b); end
        if (m_tdata_b !== 64'h0) begin bad++; $display("FAIL reset_tdata_w8 got=%h want=0", m_tdata_b); end
        rst = 0;
        @(posedge core_clk); #1;
    endtask

    task automatic test_basic;
        sel = 0; cfg_asm_en = 1;
        pay_q.delete();
        for (int i = 0; i < 255; i++) pay_q.push_back(8'(i));
        build_exp(4, 1, 254);
        drive_frame(254, 0, 0, 0, exp_q.size());
        exp_fc[0]++;
        total++;
        if (timed_out || got_q.size() != 65) begin bad++; $display("FAIL basic_count got=%0d want=65", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotl_q[i] !== (i == exp_q.size() - 1)) begin
                bad++; $display("FAIL basic_word[%0d] got=%h/%b want=%h/%b", i, got_q[i], gotl_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        if (got_q.size() == 65) begin
            total += 3;
            if (got_q[0] !== 64'h1ACFFC1D) begin bad++; $display("FAIL basic_w0 got=%h want=1acffc1d", got_q[0]); end
            if (got_q[1] !== 64'h00010203) begin bad++; $display("FAIL basic_w1 got=%h want=00010203", got_q[1]); end
            if (got_q[64] !== 64'hFCFDFE00 || gotl_q[64] !== 1'b1) begin bad++; $display("FAIL basic_w64 got=%h/%b want=fcfdfe00/1", got_q[64], gotl_q[64]); end
        end
        total += 2;
        if (fc_a !== 16'(exp_fc[0])) begin bad++; $display("FAIL basic_frame_cnt got=%0d want=%0d", fc_a, exp_fc[0]); end
        if (es_cnt != 0 || el_cnt != 0) begin bad++; $display("FAIL basic_err got=%0d/%0d want=0/0", es_cnt, el_cnt); end
    endtask

    task automatic test_backpressure;
        sel = 0; cfg_asm_en = 1;
        build_exp(4, 1, 254);
        drive_frame(254, 1, 1, 0, exp_q.size());
        exp_fc[0]++;
        total++;
        if (timed_out || got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotl_q[i] !== (i == exp_q.size() - 1)) begin
                bad++; $display("FAIL bp_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total += 2;
        if (hold_viol != 0) begin bad++; $display("FAIL bp_hold_stable got=%0d changes want=0", hold_viol); end
        if (fc_a !== 16'(exp_fc[0])) begin bad++; $display("FAIL bp_frame_cnt got=%0d want=%0d", fc_a, exp_fc[0]); end
    endtask

    task automatic test_short;
        sel = 0; cfg_asm_en = 1;
        pay_q.delete();
        for (int i = 0; i < 10; i++) pay_q.push_back(8'($urandom_range(1, 255)));
        build_exp(4, 1, 9);
        drive_frame(9, 1, 0, 0, exp_q.size());
        exp_fc[0]++;
        total++;
        if (timed_out || got_q.size() != 65) begin bad++; $display("FAIL short_count got=%0d want=65", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotl_q[i] !== (i == exp_q.size() - 1)) begin
                bad++; $display("FAIL short_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        total += 2;
        if (es_cnt != 1 || el_cnt != 0) begin bad++; $display("FAIL short_err got=%0d/%0d want=1/0", es_cnt, el_cnt); end
        if (fc_a !== 16'(exp_fc[0])) begin bad++; $display("FAIL short_frame_cnt got=%0d want=%0d", fc_a, exp_fc[0]); end
    endtask

    task automatic test_long;
        sel = 0; cfg_asm_en = 1;
        pay_q.delete();
        for (int i = 0; i < 255; i++) pay_q.push_back(8'($urandom));
        build_exp(4, 1, -1);
        drive_frame(-1, 0, 0, 0, exp_q.size());
        exp_fc[0]++;
        total += 2;
        if (timed_out || got_q.size() != 65) begin bad++; $display("FAIL long_count got=%0d want=65", got_q.size()); end
        if (es_cnt != 0 || el_cnt != 1) begin bad++; $display("FAIL long_err got=%0d/%0d want=0/1", es_cnt, el_cnt); end
        pay_q.delete();
        for (int i = 0; i < 255; i++) pay_q.push_back(8'($urandom));
        build_exp(4, 1, 254);
        drive_frame(254, 1, 0, 0, exp_q.size());
        exp_fc[0]++;
        total += 3;
        if (timed_out || got_q.size() != exp_q.size()) begin bad++; $display("FAIL long_next_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        if (got_q.size() == 0 || got_q[0] !== 64'h1ACFFC1D) begin bad++; $display("FAIL long_next_marker got=%h want=1acffc1d", got_q.size() ? got_q[0] : 64'h0); end
        if (el_cnt != 0 || fc_a !== 16'(exp_fc[0])) begin bad++; $display("FAIL long_next_state got=%0d/%0d want=0/%0d", el_cnt, fc_a, exp_fc[0]); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL long_next_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_no_asm_wide;
        sel = 1; cfg_asm_en = 0;
        pay_q.delete();
        for (int i = 0; i < 255; i++) pay_q.push_back(8'(i));
        build_exp(8, 0, 254);
        drive_frame(254, 0, 0, 0, exp_q.size());
        exp_fc[1]++;
        total++;
        if (timed_out || got_q.size() != 32) begin bad++; $display("FAIL w8_count got=%0d want=32", got_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i] || gotl_q[i] !== (i == exp_q.size() - 1)) begin
                bad++; $display("FAIL w8_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() == 32) begin
            total += 2;
            if (got_q[0] !== 64'h0001020304050607) begin bad++; $display("FAIL w8_w0 got=%h want=0001020304050607", got_q[0]); end
            if (got_q[31] !== 64'hF8F9FAFBFCFDFE00 || gotl_q[31] !== 1'b1) begin bad++; $display("FAIL w8_last got=%h/%b want=f8f9fafbfcfdfe00/1", got_q[31], gotl_q[31]); end
        end
        total++;
        if (fc_b !== 16'(exp_fc[1])) begin bad++; $display("FAIL w8_frame_cnt got=%0d want=%0d", fc_b, exp_fc[1]); end
        sel = 0;
    endtask

    task automatic test_back_to_back;
        bit asm_en;
        sel = 0;
        for (int f = 0; f < 4; f++) begin
            asm_en = 1'($urandom);
            cfg_asm_en = asm_en;
            pay_q.delete();
            for (int i = 0; i < 255; i++) pay_q.push_back(8'($urandom));
            build_exp(4, asm_en, 254);
            drive_frame(254, 1'($urandom), 1'($urandom), 0, exp_q.size());
            exp_fc[0]++;
            total += 2;
            if (timed_out || got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count[%0d] got=%0d want=%0d", f, got_q.size(), exp_q.size()); end
            if (fc_a !== 16'(exp_fc[0]) || hold_viol != 0) begin bad++; $display("FAIL b2b_state[%0d] got=%0d/%0d want=%0d/0", f, fc_a, hold_viol, exp_fc[0]); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                total++;
                if (got_q[i] !== exp_q[i] || gotl_q[i] !== (i == exp_q.size() - 1)) begin
                    bad++; $display("FAIL b2b_word[%0d][%0d] got=%h want=%h", f, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        sel = 0; cfg_asm_en = 1;
        pay_q.delete();
        for (int i = 0; i < 255; i++) pay_q.push_back(8'($urandom));
        build_exp(4, 1, 254);
        drive_frame(254, 0, 0, 11, exp_q.size());
        total++;
        if (got_q.size() != 11) begin bad++; $display("FAIL rstmid_prefix got=%0d want=11", got_q.size()); end
        m_tready = 0;
        #2 rst = 1;
        #1;
        total += 6;
        if (m_tvalid_a !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got=%b want=0", m_tvalid_a); end
        if (m_tdata_a !== 32'h0) begin bad++; $display("FAIL rstmid_tdata got=%h want=0", m_tdata_a); end
        if (m_tlast_a !== 1'b0) begin bad++; $display("FAIL rstmid_tlast got=%b want=0", m_tlast_a); end
        if (s_tready_a !== 1'b0) begin bad++; $display("FAIL rstmid_tready got=%b want=0", s_tready_a); end
        if (fc_a !== 16'd0 || fc_b !== 16'd0) begin bad++; $display("FAIL rstmid_frame_cnt got=%0d/%0d want=0/0", fc_a, fc_b); end
        if (es_a !== 1'b0 || el_a !== 1'b0) begin bad++; $display("FAIL rstmid_err got=%b%b want=00", es_a, el_a); end
        @(posedge core_clk);
        @(negedge core_clk);
        rst = 0;
        exp_fc[0] = 0; exp_fc[1] = 0;
        @(posedge core_clk); #1;
        pay_q.delete();
        for (int i = 0; i < 255; i++) pay_q.push_back(8'($urandom));
        build_exp(4, 1, 254);
        drive_frame(254, 1, 0, 0, exp_q.size());
        exp_fc[0]++;
        total += 3;
        if (timed_out || got_q.size() != exp_q.size()) begin bad++; $display("FAIL rstmid_next_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        if (got_q.size() == 0 || got_q[0] !== 64'h1ACFFC1D) begin bad++; $display("FAIL rstmid_marker got=%h want=1acffc1d", got_q.size() ? got_q[0] : 64'h0); end
        if (fc_a !== 16'(exp_fc[0])) begin bad++; $display("FAIL rstmid_next_frame_cnt got=%0d want=%0d", fc_a, exp_fc[0]); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst = 1; cfg_asm_en = 1; s_tdata = 0; s_tvalid = 0; s_tlast = 0; m_tready = 1; sel = 0;
        exp_fc[0] = 0; exp_fc[1] = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_short();
        test_long();
        test_no_asm_wide();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/asm_frame_packer.md
# asm_frame_packer

Parametrised framer that precedes each RS codeword with an attached sync marker (ASM), pads each frame to the output word width, and packs the byte stream into OUT_BYTES-wide AXI-Stream words with per-frame tlast. It sits between the RS encoder byte stream and the wide transport path. It uses the input tlast to detect short and long frames, and it applies full backpressure in both directions without an internal FIFO.

## Interface
- ASM_BYTES, 4: marker length in bytes (1..8).
- ASM_VALUE, 64'h0000_0000_1ACF_FC1D: marker value; the low ASM_BYTES bytes are used and sent MSB byte first.
- PAYLOAD_LEN, 255: payload bytes per frame (2..65535).
- OUT_BYTES, 4: output word width in bytes (1, 2, 4, 8, 16).
- PAD_BYTE, 8'h00: value used for all fill and pad bytes.
- core_clk  in  1  clock.
- rst  in  1  reset; asynchronous assert, active-high.
- cfg_asm_en  in  1  insert the marker; sampled only on the IDLE→frame-start transition.
- s_axis_input_tdata  in  8  payload byte.
- s_axis_input_tvalid  in  1  byte valid.
- s_axis_input_tlast  in  1  last payload byte of the codeword.
- s_axis_input_tready  out  1  byte accepted when tvalid and tready are both high.
- m_axis_output_tdata  out  8*OUT_BYTES  packed word; the first byte of the word is in the MSB lane.
- m_axis_output_tvalid  out  1  word valid.
- m_axis_output_tlast  out  1  last word of the frame.
- m_axis_output_tready  in  1  downstream accept.
- frame_cnt  out  16  completed frames, counting the frame-final word handshake; wraps at 65535→0.
- err_short  out  1  one-cycle pulse: tlast was accepted before payload byte PAYLOAD_LEN-1.
- err_long  out  1  one-cycle pulse: payload byte PAYLOAD_LEN-1 was accepted without tlast.

## Operation
- Frame length is F = A + PAYLOAD_LEN + P, where A = ASM_BYTES if the marker is enabled and 0 otherwise, and P = (OUT_BYTES − (A+PAYLOAD_LEN) mod OUT_BYTES) mod OUT_BYTES.
- Both values of P are localparams; the one matching the latched cfg_asm_en is used.
- Defaults: F = 260 bytes (65 words) with the marker, and 256 bytes with it off.
- Byte slot: at most one byte enters the packer per cycle.
- A byte may enter when `slot_ok = !(lane==OUT_BYTES-1 && m_tvalid && !m_tready)`.
- State IDLE: s_tready=0. Go to ASM when s_tvalid=1, latching cfg_asm_en. If the marker is disabled, go to DATA instead.
- State ASM: one marker byte per slot_ok cycle, MSB byte first. asm_cnt counts 0..A-1. After byte A-1, go to DATA.
- State DATA: s_tready=slot_ok. Each accepted byte increments data_cnt (width ⌈log2 PAYLOAD_LEN⌉+1).
  - tlast on data_cnt<PAYLOAD_LEN-1: pulse err_short and go to FILL.
  - Byte PAYLOAD_LEN-1 accepted: pulse err_long if tlast=0. Go to PAD if P>0, else IDLE.
- State FILL: insert PAD_BYTE per slot_ok until PAYLOAD_LEN payload positions are filled, then go to PAD/IDLE as for DATA. s_tready=0.
- State PAD: insert P PAD_BYTE bytes per slot_ok, then go to IDLE. s_tready=0.
- Packer: an assembly register, a lane counter 0..OUT_BYTES-1, and an output register.
  - When the byte in lane OUT_BYTES-1 enters, the assembled word moves to the output register, m_tvalid=1, and m_tlast=1 if that byte is frame byte F-1.
  - The output register holds its value while m_tvalid && !m_tready.
- Any overrun or underrun of the internal counters is a design error.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tlast=0, s_tready=0, frame_cnt=0, err_short=0, err_long=0; state=IDLE, all counters 0.
- Latency: a word's m_tvalid rises in the cycle after its last byte slot.
- IDLE→ASM takes 1 cycle after the first s_tvalid; the marker does not consume an input byte.
- Throughput with m_tready held high: 1 byte per cycle sustained, with no bubble at word boundaries.
  - One idle cycle per frame, for the IDLE state.
- Output register loaded in the same cycle m_tready consumes the old word: no bubble.
- Backpressure: a stalled word stops byte entry only while the lane is OUT_BYTES-1.
  - m_tdata/m_tlast are stable while m_tvalid && !m_tready.
- Error pulses are asserted in the cycle after the offending handshake.
- rst mid-frame discards the partial word and the held output word.
  - The next frame begins with the marker.

## Test plan
- Defaults, marker on, bytes 0x00..0xFE with tlast on the last byte, m_tready=1 → 65 words:
  - word 0 = 0x1ACFFC1D, word 1 = 0x00010203, word 64 = 0xFCFDFE00 with tlast=1.
  - frame_cnt=1, no error pulses.
- Same stimulus with m_tready toggling 1 cycle on / 2 cycles off and random s_tvalid gaps → identical 65-word sequence, with no data change while stalled.
- tlast on payload byte 9 → err_short pulse; payload positions 10..254 plus the pad are 0x00; 65 words total, tlast on word 64.
- 255 bytes without tlast, then the next frame → err_long pulse; the next frame starts with 0x1ACFFC1D.
- cfg_asm_en=0, OUT_BYTES=8 → 32 words; word 0 = 0x0001020304050607; the last word ends 0xFE00 with tlast.
- rst asserted after word 10 of a frame, then a new frame → all outputs at reset values; the output restarts with the marker; frame_cnt=0.
